// File: rtl/duc_hb_interp_firx2_h0.sv
// Halfband interpolate-by-2 FIR for the DUC: symmetric 8-tap E0 branch plus centre-tap E1, one lane each for I and Q.
// Define DUC_HB_SAT_COUNT_EN to build the saturation event counter behind o_sat_count.

module duc_hb_interp_firx2_h0_lane #(
   parameter int WIDTH = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_x,
   output logic [WIDTH-1:0] o_even,
   output logic [WIDTH-1:0] o_odd,
   output logic             o_even_sat,
   output logic             o_odd_sat
);
   localparam int TAPS    = 8;
   localparam int NPAIR   = TAPS / 2;
   localparam int PA_W    = WIDTH + 1;
   localparam int CF_W    = 18;
   localparam int PR_W    = PA_W + CF_W;
   localparam int ACC_W   = PR_W + 3;
   localparam int FRAC    = 17;
   localparam int CTR_STG = 5;

   function automatic logic signed [CF_W-1:0] coef(input int k);
      case (k)
         0:       coef = -18'sd474;
         1:       coef = 18'sd3818;
         2:       coef = -18'sd16819;
         default: coef = 18'sd79010;
      endcase
   endfunction

   // Returns {clamped, result}; half-up rounding then clamp when the dropped
   // high bits disagree with the result sign.
   function automatic logic [WIDTH:0] rnd_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0]   r;
      logic [ACC_W-WIDTH-17:0]   hi;
      r  = a + ACC_W'(65536);
      hi = r[ACC_W-1:WIDTH+16];
      if ((&hi) || !(|hi))
         rnd_sat = {1'b0, r[WIDTH+16:FRAC]};
      else if (r[ACC_W-1])
         rnd_sat = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      else
         rnd_sat = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   logic [TAPS-1:0][WIDTH-1:0]    tap_q, tap_d;
   logic [NPAIR-1:0][PA_W-1:0]    pa_q, pa_d;
   logic [NPAIR-1:0][PR_W-1:0]    prod_q, prod_d;
   logic [1:0][ACC_W-1:0]         s1_q, s1_d;
   logic [ACC_W-1:0]              acc_q, acc_d, acc_dly_q, acc_dly_d;
   logic [CTR_STG-1:0][WIDTH-1:0] ctr_q, ctr_d;
   logic [WIDTH:0]                even_q, even_d, odd_q, odd_d;

   always_comb begin
      tap_d = tap_q;
      if (i_shift)
         tap_d = {tap_q[TAPS-2:0], i_x};
      for (int k = 0; k < NPAIR; k++) begin
         pa_d[k]   = PA_W'($signed(tap_q[k])) + PA_W'($signed(tap_q[TAPS-1-k]));
         prod_d[k] = PR_W'($signed(pa_q[k])) * PR_W'(coef(k));
      end
      s1_d[0]   = ACC_W'($signed(prod_q[0])) + ACC_W'($signed(prod_q[1]));
      s1_d[1]   = ACC_W'($signed(prod_q[2])) + ACC_W'($signed(prod_q[3]));
      acc_d     = s1_q[0] + s1_q[1];
      // Extra stage so the even sample lands in the output register at T+7.
      acc_dly_d = acc_q;
      ctr_d     = {ctr_q[CTR_STG-2:0], tap_q[3]};
      even_d    = rnd_sat(acc_dly_q);
      odd_d     = rnd_sat({{(ACC_W-WIDTH-FRAC){ctr_q[CTR_STG-1][WIDTH-1]}},
                           ctr_q[CTR_STG-1], {FRAC{1'b0}}});
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         tap_q     <= '0;
         pa_q      <= '0;
         prod_q    <= '0;
         s1_q      <= '0;
         acc_q     <= '0;
         acc_dly_q <= '0;
         ctr_q     <= '0;
         even_q    <= '0;
         odd_q     <= '0;
      end else begin
         tap_q     <= tap_d;
         pa_q      <= pa_d;
         prod_q    <= prod_d;
         s1_q      <= s1_d;
         acc_q     <= acc_d;
         acc_dly_q <= acc_dly_d;
         ctr_q     <= ctr_d;
         even_q    <= even_d;
         odd_q     <= odd_d;
      end
   end

   assign o_even     = even_q[WIDTH-1:0];
   assign o_even_sat = even_q[WIDTH];
   assign o_odd      = odd_q[WIDTH-1:0];
   assign o_odd_sat  = odd_q[WIDTH];
endmodule

module duc_hb_interp_firx2_h0 #(
   parameter int WIDTH = 16
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_inph_data,
   input  logic [WIDTH-1:0] i_quad_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_inph_data,
   output logic [WIDTH-1:0] o_quad_data,
   output logic             o_valid,
   output logic [15:0]      o_sat_count
);
   localparam int NUM_LANES = 2;
   localparam int STAGES    = 7;

   typedef enum logic {PH0, PH1} ph_e;

   ph_e                             ph_q, ph_d;
   logic                            accept;
   logic [STAGES:0]                 vld_pipe_q, vld_pipe_d;
   logic [NUM_LANES-1:0][WIDTH-1:0] lane_x, lane_even, lane_odd;
   logic [NUM_LANES-1:0]            lane_even_sat, lane_odd_sat;
   logic [NUM_LANES-1:0][WIDTH-1:0] out_q, out_d, odd_hold_q, odd_hold_d;
   logic                            out_vld_q, out_vld_d;
   logic                            odd_sat_q, odd_sat_d;
   logic                            sat_evt;

   assign o_ready = (ph_q == PH0) && !i_reset;
   assign accept  = i_valid && o_ready;
   assign lane_x  = {i_quad_data, i_inph_data};

   always_comb begin
      ph_d = ph_q;
      case (ph_q)
         PH0:     if (accept) ph_d = PH1;
         PH1:     ph_d = PH0;
         default: ph_d = PH0;
      endcase
   end

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         duc_hb_interp_firx2_h0_lane #(.WIDTH(WIDTH)) u_lane (
            .i_clock    (i_clock),
            .i_reset    (i_reset),
            .i_shift    (accept),
            .i_x        (lane_x[g]),
            .o_even     (lane_even[g]),
            .o_odd      (lane_odd[g]),
            .o_even_sat (lane_even_sat[g]),
            .o_odd_sat  (lane_odd_sat[g])
         );
      end
   endgenerate

   // Even sample loads at T+7, odd is parked one cycle and follows at T+8.
   always_comb begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:0], accept};
      out_d      = out_q;
      odd_hold_d = odd_hold_q;
      odd_sat_d  = odd_sat_q;
      sat_evt    = 1'b0;
      out_vld_d  = vld_pipe_q[STAGES-1] | vld_pipe_q[STAGES];
      if (vld_pipe_q[STAGES-1]) begin
         out_d      = lane_even;
         odd_hold_d = lane_odd;
         odd_sat_d  = |lane_odd_sat;
         sat_evt    = |lane_even_sat;
      end else if (vld_pipe_q[STAGES]) begin
         out_d   = odd_hold_q;
         sat_evt = odd_sat_q;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         ph_q       <= PH0;
         vld_pipe_q <= '0;
         out_q      <= '0;
         odd_hold_q <= '0;
         odd_sat_q  <= 1'b0;
         out_vld_q  <= 1'b0;
      end else begin
         ph_q       <= ph_d;
         vld_pipe_q <= vld_pipe_d;
         out_q      <= out_d;
         odd_hold_q <= odd_hold_d;
         odd_sat_q  <= odd_sat_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign o_inph_data = out_q[0];
   assign o_quad_data = out_q[1];
   assign o_valid     = out_vld_q;

`ifdef DUC_HB_SAT_COUNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (sat_evt && (sat_cnt_q != 16'hFFFF))
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) sat_cnt_q <= '0;
      else         sat_cnt_q <= sat_cnt_d;
   end

   assign o_sat_count = sat_cnt_q;
`else
   logic sat_unused;
   assign sat_unused  = sat_evt;
   assign o_sat_count = 16'd0;
`endif
endmodule

// File: tb/tb_duc_hb_interp_firx2_h0.sv
// Directed bench for the halfband x2 interpolator: reset, impulse, DC, saturation, handshake, mid-run reset.
module tb_duc_hb_interp_firx2_h0;
   localparam int W = 16;
`ifdef DUC_HB_SAT_COUNT_EN
   localparam int SAT_ON = 1;
`else
   localparam int SAT_ON = 0;
`endif

   logic         i_clock = 1'b0;
   logic         i_reset = 1'b1;
   logic [W-1:0] i_inph_data = '0;
   logic [W-1:0] i_quad_data = '0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [W-1:0] o_inph_data;
   logic [W-1:0] o_quad_data;
   logic         o_valid;
   logic [15:0]  o_sat_count;

   always #5 i_clock = ~i_clock;

   duc_hb_interp_firx2_h0 #(.WIDTH(W)) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_inph_data (i_inph_data),
      .i_quad_data (i_quad_data),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_inph_data (o_inph_data),
      .o_quad_data (o_quad_data),
      .o_valid     (o_valid),
      .o_sat_count (o_sat_count)
   );

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   logic signed [W-1:0] qi[$];
   logic signed [W-1:0] qq[$];
   int qc[$];
   int acc_c[$];

   always @(posedge i_clock) cyc <= cyc + 1;

   always @(negedge i_clock) begin
      if (o_valid === 1'b1) begin
         qi.push_back($signed(o_inph_data));
         qq.push_back($signed(o_quad_data));
         qc.push_back(cyc);
      end
      if (i_valid === 1'b1 && o_ready === 1'b1) acc_c.push_back(cyc);
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic clr();
      qi.delete(); qq.delete(); qc.delete(); acc_c.delete();
   endtask

   task automatic put(input int i, input int q);
      @(posedge i_clock);
      #1;
      i_valid     = 1'b1;
      i_inph_data = i[W-1:0];
      i_quad_data = q[W-1:0];
      @(posedge i_clock);
      #1;
      i_valid     = 1'b0;
      i_inph_data = '0;
      i_quad_data = '0;
   endtask

   task automatic do_reset(input string pfx);
      i_reset = 1'b1;
      i_valid = 1'b0;
      repeat (3) tick();
      @(negedge i_clock);
      chk({pfx, "_rst_ready"}, o_ready, 0);
      chk({pfx, "_rst_valid"}, o_valid, 0);
      chk({pfx, "_rst_i"}, $signed(o_inph_data), 0);
      chk({pfx, "_rst_q"}, $signed(o_quad_data), 0);
      chk({pfx, "_rst_sat"}, o_sat_count, 0);
      @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      @(negedge i_clock);
      chk({pfx, "_ready_after_rst"}, o_ready, 1);
      clr();
   endtask

   task automatic run_impulse(input string pfx);
      int ev[8] = '{-59, 477, -2102, 9876, 9876, -2102, 477, -59};
      put(16384, 0);
      for (int k = 0; k < 7; k++) put(0, 0);
      repeat (14) tick();
      chk({pfx, "_count"}, qi.size(), 16);
      if (qi.size() >= 16 && acc_c.size() > 0) begin
         chk({pfx, "_latency"}, qc[0] - acc_c[0], 8);
         chk({pfx, "_contig"}, qc[15] - qc[0], 15);
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_even%0d", pfx, k), qi[2*k], ev[k]);
            chk($sformatf("%s_odd%0d", pfx, k), qi[2*k+1], (k == 3) ? 16384 : 0);
            chk($sformatf("%s_qe%0d", pfx, k), qq[2*k], 0);
            chk($sformatf("%s_qo%0d", pfx, k), qq[2*k+1], 0);
         end
      end
   endtask

   initial begin
      // Reset then idle
      do_reset("init");
      repeat (4) tick();
      chk("idle_valid", o_valid, 0);
      chk("idle_count", qi.size(), 0);

      // Impulse
      run_impulse("imp1");

      // DC full scale on both rails
      do_reset("dc");
      for (int k = 0; k < 12; k++) put(32767, 32767);
      repeat (14) tick();
      chk("dc_count", qi.size(), 24);
      if (qi.size() >= 24) begin
         chk("dc_even0", qi[0], -118);
         chk("dc_even1", qi[2], 836);
         chk("dc_even2", qi[4], -3369);
         chk("dc_even3", qi[6], 16383);
         chk("dc_even4_clamp", qi[8], 32767);
         chk("dc_even5", qi[10], 31931);
         chk("dc_even6_clamp", qi[12], 32767);
         for (int k = 7; k < 12; k++) chk($sformatf("dc_even%0d", k), qi[2*k], 32767);
         chk("dc_odd2", qi[5], 0);
         for (int k = 3; k < 12; k++) chk($sformatf("dc_odd%0d", k), qi[2*k+1], 32767);
         chk("dc_q_even0", qq[0], -118);
         chk("dc_q_even7", qq[14], 32767);
      end
      chk("dc_hold_valid", o_valid, 0);
      chk("dc_hold_i", $signed(o_inph_data), 32767);
      chk("dc_hold_q", $signed(o_quad_data), 32767);
      chk("dc_sat_count", o_sat_count, SAT_ON * 2);

      // Saturation pattern
      do_reset("sat");
      begin
         int xs[8] = '{-32768, 32767, -32768, 32767, 32767, -32768, 32767, -32768};
         for (int k = 0; k < 8; k++) put(xs[k], 0);
      end
      for (int k = 0; k < 4; k++) put(0, 0);
      repeat (14) tick();
      chk("sat_count_out", qi.size(), 24);
      if (qi.size() >= 24) begin
         chk("sat_even3", qi[6], -25030);
         chk("sat_odd3", qi[7], -32768);
         chk("sat_odd4", qi[9], 32767);
         chk("sat_even7_clamp", qi[14], 32767);
         chk("sat_q_even7", qq[14], 0);
      end
      chk("sat_counter", o_sat_count, SAT_ON);

      // Handshake with i_valid held high
      do_reset("hs");
      @(posedge i_clock);
      #1;
      i_valid     = 1'b1;
      i_inph_data = 16'd100;
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clock);
         chk($sformatf("hs_ready%0d", k), o_ready, (k % 2 == 0) ? 1 : 0);
         @(posedge i_clock);
         #1;
      end
      i_valid     = 1'b0;
      i_inph_data = '0;
      repeat (14) tick();
      chk("hs_accepts", acc_c.size(), 5);
      chk("hs_outputs", qi.size(), 10);
      if (qi.size() >= 10 && acc_c.size() > 0) begin
         chk("hs_latency", qc[0] - acc_c[0], 8);
         chk("hs_contig", qc[9] - qc[0], 9);
         chk("hs_odd0", qi[1], 0);
         chk("hs_even3", qi[6], 50);
         chk("hs_odd3", qi[7], 100);
      end

      // Reset three cycles after an accept
      do_reset("mid");
      put(16384, 0);
      repeat (2) tick();
      i_reset = 1'b1;
      repeat (2) tick();
      i_reset = 1'b0;
      repeat (16) tick();
      chk("mid_no_valid", qi.size(), 0);
      clr();
      run_impulse("imp2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
